// File: rtl/ted_bus_responder_pkg.sv
// Shared types and constants for the TED bus responder.
// Holds the steal FSM encoding, register offsets and default window base.
package ted_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_STEAL   = 2'd2,
        ST_RELEASE = 2'd3
    } steal_state_t;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LEN    = 3'd1;
    localparam logic [2:0] REG_STAT   = 3'd2;
    localparam logic [2:0] REG_CNT_LO = 3'd3;
    localparam logic [2:0] REG_CNT_HI = 3'd4;
    localparam logic [2:0] REG_SCR0   = 3'd5;
    localparam logic [2:0] REG_SCR1   = 3'd6;
    localparam logic [2:0] REG_SCR2   = 3'd7;

    function automatic logic [7:0] stat_byte(
        input logic         busy,
        input steal_state_t st
    );
        return {busy, 5'b00000, st};
    endfunction

endpackage

// File: rtl/ted_bus_responder_if.sv
// Link between the register block and the steal sequencer.
// The master issues trigger and length; the slave reports bus ownership.
interface ted_bus_responder_if;
    import ted_bus_responder_pkg::*;

    logic         trigger;
    logic [7:0]   len;
    logic         aec;
    logic         _rdy;
    logic         busy;
    steal_state_t state;

    modport master (
        output trigger,
        output len,
        input  aec,
        input  _rdy,
        input  busy,
        input  state
    );

    modport slave (
        input  trigger,
        input  len,
        output aec,
        output _rdy,
        output busy,
        output state
    );

endinterface

// File: rtl/ted_steal_fsm.sv
// Cycle-steal sequencer: stall the CPU, take the bus for LEN cycles,
// then hand it back through a one-cycle release.
module ted_steal_fsm
    import ted_bus_responder_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 3
) (
    input  logic               clock,
    input  logic               _reset,
    ted_bus_responder_if.slave bus
);

    localparam logic [7:0] STALL_LAST = 8'(STALL_CYCLES - 1);

    steal_state_t state_q;
    steal_state_t state_d;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic [7:0]   len_q;
    logic [7:0]   len_d;

    always_ff @(negedge clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            len_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Length is frozen on entry to STALL; later LEN writes wait a sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.trigger) begin
                    state_d = ST_STALL;
                    cnt_d   = 8'h00;
                    len_d   = bus.len;
                end
            end
            ST_STALL: begin
                if (cnt_q == STALL_LAST) begin
                    cnt_d   = 8'h00;
                    state_d = (len_q == 8'h00) ? ST_RELEASE : ST_STEAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STEAL: begin
                if (cnt_q == len_q - 8'd1) begin
                    cnt_d   = 8'h00;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.aec  = 1'b1;
        bus._rdy = 1'b1;
        unique case (state_q)
            ST_STALL: begin
                bus._rdy = 1'b0;
            end
            ST_STEAL: begin
                bus.aec  = 1'b0;
                bus._rdy = 1'b0;
            end
            ST_RELEASE: begin
                bus._rdy = 1'b0;
            end
            default: begin
                bus.aec  = 1'b1;
                bus._rdy = 1'b1;
            end
        endcase
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.state = state_q;

endmodule

// File: rtl/ted_bus_responder.sv
// 8-byte register window on the 7501 bus plus a cycle-steal DMA trigger.
// All state moves on the falling edge of phi2, where bus writes land.
module ted_bus_responder
    import ted_bus_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned STALL_CYCLES = 3
) (
    input  logic        _reset,
    input  logic        clock,
    input  logic [15:0] address_7501,
    input  logic        r_w_7501,
    inout  wire  [7:0]  data_7501,
    output logic        aec,
    output logic        _rdy_7501,
    input  logic        dma_req,
    output logic        dma_busy
);

    ted_bus_responder_if steal_if ();

    logic [2:0]  offset;
    logic        hit;
    logic        rd_hit;
    logic        wr_hit;
    logic        data_oe;
    logic        ctrl_wr;
    logic        sw_trig;
    logic        enable;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic [7:0]  ctrl_q;
    logic [7:0]  len_q;
    logic [7:0]  hi_latch_q;
    logic [7:0]  scr5_q;
    logic [7:0]  scr6_q;
    logic [7:0]  scr7_q;
    logic [15:0] cnt_q;

    // The window vanishes while the bus is stolen.
    assign offset  = address_7501[2:0];
    assign hit     = (address_7501[15:3] == BASE_ADDR[15:3]) && steal_if.aec;
    assign rd_hit  = hit && r_w_7501;
    assign wr_hit  = hit && !r_w_7501;
    assign wr_data = data_7501;

    assign data_oe   = rd_hit && clock;
    assign data_7501 = data_oe ? rd_data : 8'hzz;

    // A CTRL write setting enable and trigger together starts a sequence.
    assign ctrl_wr = wr_hit && (offset == REG_CTRL);
    assign sw_trig = ctrl_wr && wr_data[1];
    assign enable  = ctrl_wr ? wr_data[0] : ctrl_q[0];

    assign steal_if.trigger = enable && (dma_req || sw_trig);
    assign steal_if.len     = len_q;

    assign aec       = steal_if.aec;
    assign _rdy_7501 = steal_if._rdy;
    assign dma_busy  = steal_if.busy;

    ted_steal_fsm #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_steal_fsm (
        .clock  (clock),
        ._reset (_reset),
        .bus    (steal_if)
    );

    always_comb begin
        rd_data = 8'h00;
        unique case (1'b1)
            offset == REG_CTRL:   rd_data = ctrl_q;
            offset == REG_LEN:    rd_data = len_q;
            offset == REG_STAT:   rd_data = stat_byte(steal_if.busy,
                                                      steal_if.state);
            offset == REG_CNT_LO: rd_data = cnt_q[7:0];
            offset == REG_CNT_HI: rd_data = hi_latch_q;
            offset == REG_SCR0:   rd_data = scr5_q;
            offset == REG_SCR1:   rd_data = scr6_q;
            offset == REG_SCR2:   rd_data = scr7_q;
            default:              rd_data = 8'h00;
        endcase
    end

    // Reading CNT_LO snapshots the high byte so the pair reads coherently.
    always_ff @(negedge clock or negedge _reset) begin
        if (!_reset) begin
            ctrl_q     <= 8'h00;
            len_q      <= 8'h00;
            hi_latch_q <= 8'h00;
            scr5_q     <= 8'h00;
            scr6_q     <= 8'h00;
            scr7_q     <= 8'h00;
            cnt_q      <= 16'h0000;
        end else begin
            cnt_q <= cnt_q + 16'd1;
            if (rd_hit && (offset == REG_CNT_LO)) begin
                hi_latch_q <= cnt_q[15:8];
            end
            if (wr_hit) begin
                unique case (1'b1)
                    offset == REG_CTRL: ctrl_q <= {wr_data[7:2], 1'b0, wr_data[0]};
                    offset == REG_LEN:  len_q  <= wr_data;
                    offset == REG_SCR0: scr5_q <= wr_data;
                    offset == REG_SCR1: scr6_q <= wr_data;
                    offset == REG_SCR2: scr7_q <= wr_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ted_bus_responder.md
TED_BUS_RESPONDER -- requirements
Module: ted_bus_responder

Interface
REQ-001 SHALL have parameters: BASE_ADDR, 16'hFF00, base of 8-byte register window; STALL_CYCLES, 3, cycles _rdy_7501 is held low before AEC is dropped.
REQ-002 SHALL have ports: _reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: clock  in  1  single system clock (phi2); high half = data phase.
REQ-004 SHALL have ports: address_7501  in  16  CPU-side bus address (high-Z during steal).
REQ-005 SHALL have ports: r_w_7501  in  1  1 = read, 0 = write.
REQ-006 SHALL have ports: data_7501  inout  8  bus data; driven only on register reads.
REQ-007 SHALL have ports: aec  out  1  1 = CPU owns the bus, 0 = cycles stolen.
REQ-008 SHALL have ports: _rdy_7501  out  1  active-low stall request to the CPU.
REQ-009 SHALL have ports: dma_req  in  1  one-cycle request pulse to start a steal sequence.
REQ-010 SHALL have ports: dma_busy  out  1  high while FSM is not IDLE.

Function
REQ-011 All state SHALL update on the negedge of clock, the same edge the bus captures writes on.
REQ-012 Window hit SHALL be address_7501[15:3] == BASE_ADDR[15:3] and aec == 1.
REQ-013 Registers: +0 CTRL rw (bit0 enable, bit1 sw trigger, self-clearing); +1 LEN rw (steal length 0-255); +2 STAT ro ({dma_busy, 5'b0, state[1:0]}); +3 CNT_LO ro; +4 CNT_HI ro; +5..+7 scratch rw.
REQ-014 A read hit SHALL drive data_7501 with the register value while clock = 1; otherwise data_7501 SHALL be high-Z.
REQ-015 A write hit SHALL capture data_7501 into the register at the negedge ending the cycle; writes to ro registers SHALL be ignored.
REQ-016 CNT SHALL be a 16-bit free-running cycle counter wrapping from FFFF to 0000; a read of CNT_LO SHALL latch CNT_HI so that the two bytes read coherently.
REQ-017 FSM states SHALL be IDLE, STALL, STEAL, RELEASE, encoded 0-3.
REQ-018 IDLE -> STALL SHALL occur on dma_req = 1 or a CTRL.bit1 write, but only when CTRL.bit0 = 1; the trigger SHALL be ignored when enable = 0.
REQ-019 In STALL, _rdy_7501 SHALL be 0 and aec 1 for exactly STALL_CYCLES cycles, then go to STEAL, or to RELEASE if LEN = 0.
REQ-020 In STEAL, aec and _rdy_7501 SHALL both be 0 for exactly LEN cycles, with the length sampled on entry to STALL; window accesses SHALL be ignored.
REQ-021 RELEASE SHALL last 1 cycle with aec = 1 and _rdy_7501 = 0, then go to IDLE with _rdy_7501 = 1.
REQ-022 Triggers arriving while dma_busy = 1 SHALL be dropped, with no queueing.
REQ-023 A LEN write during a sequence SHALL affect only the next sequence.
REQ-024 If dma_req and a CTRL.bit1 write occur in the same cycle, they SHALL start one sequence.
REQ-025 dma_busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 On _reset = 0, the block SHALL asynchronously enter IDLE with aec = 1, _rdy_7501 = 1, dma_busy = 0, data_7501 high-Z, and CTRL, LEN, CNT, scratch and latch all 0.
REQ-027 Reset asserted mid-sequence SHALL immediately release the bus (aec = 1, _rdy_7501 = 1).
REQ-028 After reset deasserts, the block SHALL ignore triggers until enable is written.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the register offset constants and the default BASE_ADDR.
REQ-030 The steal sequencer SHALL be one sub-module, ted_steal_fsm (inputs trigger and len; outputs aec, _rdy, busy, state); the register file and bus decode SHALL stay in the top module.

Verification
REQ-031 The bench SHALL cover: write FF05 = 5A, then read FF05 -> data_7501 = 5A during clock high, and high-Z otherwise.
REQ-032 The bench SHALL cover: CTRL = 01, LEN = 04, dma_req pulse -> _rdy_7501 low 3 cycles, then aec low 4 cycles, 1 RELEASE cycle, IDLE, dma_busy high for 8 cycles.
REQ-033 The bench SHALL cover: LEN = 00 with trigger -> STALL 3 cycles, RELEASE 1 cycle, aec never low.
REQ-034 The bench SHALL cover: second dma_req during STEAL -> ignored; exactly one sequence occurs.
REQ-035 The bench SHALL cover: _reset pulsed during STEAL -> aec = 1 and _rdy_7501 = 1 at once, STAT reads 00 after reset.
REQ-036 The bench SHALL cover: CNT preloaded near FFFF by running 65535 cycles; read FF03 then FF04 -> coherent pair across the FFFF -> 0000 wrap.
